// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// One outstanding imem fetch; a skid buffer absorbs a response that lands during a stall.
module if_stage #(
  parameter int unsigned       PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_write,
  input  logic                IF_ID_write,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] IF_ID_pc,
  output logic [31:0]         IF_ID_instr,
  output logic                IF_ID_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_KILL = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_buf;
  logic                r_buf_valid;
  logic [PC_WIDTH-1:0] r_if_id_pc;
  logic [31:0]         r_if_id_instr;
  logic                r_if_id_valid;

  logic                w_stall;
  logic                w_deliver;
  logic                w_capture;
  logic [31:0]         w_deliver_instr;
  logic [PC_WIDTH-1:0] w_redirect_pc;

  assign w_stall       = ~(pc_write & IF_ID_write);
  assign w_redirect_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};

  always_comb begin
    w_state_nxt     = r_state;
    w_deliver       = 1'b0;
    w_capture       = 1'b0;
    w_deliver_instr = imem_rdata;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid)  w_state_nxt = imem_gnt ? S_KILL : S_REQ;
        else if (imem_gnt)   w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
        end else if (imem_rvalid) begin
          if (w_stall) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_deliver   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        w_deliver_instr = r_buf;
        if (redirect_valid) begin
          w_state_nxt = S_REQ;
        end else if (!w_stall && r_buf_valid) begin
          w_deliver   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      // A redirect here still leaves the old response owed, so only rvalid exits.
      S_KILL: if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_buf       <= NOP_INSTR;
      r_buf_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid)  r_pc <= w_redirect_pc;
      else if (w_deliver)  r_pc <= r_pc + PC_WIDTH'(4);
      if (redirect_valid || w_deliver) begin
        r_buf_valid <= 1'b0;
      end else if (w_capture) begin
        r_buf       <= imem_rdata;
        r_buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (w_deliver) begin
      r_if_id_pc    <= r_pc;
      r_if_id_instr <= w_deliver_instr;
      r_if_id_valid <= 1'b1;
    end else if (!w_stall) begin
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign IF_ID_pc    = r_if_id_pc;
  assign IF_ID_instr = r_if_id_instr;
  assign IF_ID_valid = r_if_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, IF_ID_write, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc, IF_ID_instr;
  logic        IF_ID_valid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic v);
    chk({tag, "_pc"}, IF_ID_pc, pc);
    chk({tag, "_instr"}, IF_ID_instr, ins);
    chk({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    tick(); tick();
    chk_req("rst", 1'b0, 32'h0);
    chk_ifid("rst", 32'h0, NOP, 1'b0);

    // 1: first fetch, 1-cycle memory
    rst_n = 1'b1; imem_gnt = 1'b1;
    tick();
    chk_req("t1_req", 1'b1, 32'h0);
    tick();
    chk_req("t1_wait", 1'b0, 32'h0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk_ifid("t1_load", 32'h0, 32'h0050_0093, 1'b1);
    chk_req("t1_next", 1'b1, 32'h4);

    // 2: stall across rvalid, skid buffer holds the word
    imem_gnt = 1'b1;
    tick();
    chk_ifid("t2_bub", 32'h0, NOP, 1'b0);
    imem_gnt = 1'b0; pc_write = 1'b0; IF_ID_write = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      chk_ifid("t2_hold", 32'h0, NOP, 1'b0);
      chk_req("t2_hold", 1'b0, 32'h4);
      if (i < 2) tick();
    end
    pc_write = 1'b1; IF_ID_write = 1'b1;
    tick();
    chk_ifid("t2_rel", 32'h4, 32'h00A0_0113, 1'b1);
    chk_req("t2_rel", 1'b1, 32'h8);

    // 3: redirect in WAIT, late response discarded
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk_req("t3_kill", 1'b0, 32'h100);
    tick();
    chk_req("t3_kill2", 1'b0, 32'h100);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk_ifid("t3_drop", 32'h4, NOP, 1'b0);
    chk_req("t3_next", 1'b1, 32'h100);

    // 4: redirect while stalled flushes a valid IF/ID
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_8233;
    tick();
    imem_rvalid = 1'b0; pc_write = 1'b0; IF_ID_write = 1'b0;
    chk_ifid("t4_load", 32'h100, 32'h0020_8233, 1'b1);
    tick();
    chk_ifid("t4_stall", 32'h100, 32'h0020_8233, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1;
    chk("t4_flush_instr", IF_ID_instr, NOP);
    chk("t4_flush_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk_req("t4_redir", 1'b1, 32'hFFFF_FFFC);

    // 5: pc wrap at top of address space
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
    tick();
    imem_rvalid = 1'b0;
    chk_ifid("t5_load", 32'hFFFF_FFFC, 32'h0000_0073, 1'b1);
    chk_req("t5_wrap", 1'b1, 32'h0);

    // 6: reset during WAIT, stray response after release
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    chk_req("t6_pre", 1'b1, 32'h4);
    tick();
    imem_gnt = 1'b0;
    chk_req("t6_wait", 1'b0, 32'h4);
    rst_n = 1'b0;
    #1;
    chk_req("t6_async", 1'b0, 32'h0);
    chk_ifid("t6_async", 32'h0, NOP, 1'b0);
    tick();
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk_ifid("t6_stray", 32'h0, NOP, 1'b0);
    chk_req("t6_req", 1'b1, 32'h0);
    tick();
    chk_ifid("t6_after", 32'h0, NOP, 1'b0);
    chk_req("t6_after", 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
